btn_conditioner: RTL

Conditions the board's raw push-button inputs before they reach the LED blink/counter logic clocked by `sys_clk_125`. Each button is synchronised into the clock domain and debounced by a per-button state machine. The block produces a clean level plus single-cycle press, release and (optionally) long-press pulses. Downstream logic uses these pulses to step counters or change blink rates instead of sampling bouncing pins.

---
 rtl/btn_pkg.sv | 19 +
 rtl/btn_debounce_ch.sv | 146 ++++++++++++++
 rtl/btn_conditioner.sv | 34 +++
 3 files changed

// File: rtl/btn_pkg.sv
// Shared types and defaults for the push-button conditioner.
package btn_pkg;

  typedef enum logic [1:0] {
    ST_LO  = 2'd0,
    CHK_HI = 2'd1,
    ST_HI  = 2'd2,
    CHK_LO = 2'd3
  } btn_state_e;

  localparam int DEBOUNCE_CYC_DEF = 1_250_000;
  localparam int LONG_CYC_DEF     = 125_000_000;

  // Counter width that stays legal when the terminal count is 1.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, debounce FSM and, when
// BTN_LONG_PRESS_EN is defined, the long-press hold counter.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
  parameter int LONG_CYC     = LONG_CYC_DEF
) (
  input  logic sys_clk_125,
  input  logic rst_n,
  input  logic btn,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long
);

  localparam int CW = cnt_w(DEBOUNCE_CYC);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYC - 1);

  btn_state_e    state_q, state_d;
  logic [CW-1:0] db_cnt_q, db_cnt_d;
  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;

  always_ff @(posedge sys_clk_125 or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      state_q   <= ST_LO;
      db_cnt_q  <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= btn;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      db_cnt_q  <= db_cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Counter is compared before incrementing, so it never exceeds DB_LAST.
  always_comb begin
    state_d   = state_q;
    db_cnt_d  = db_cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    unique case (state_q)
      ST_LO: begin
        if (sync2_q) begin
          state_d  = CHK_HI;
          db_cnt_d = '0;
        end
      end
      CHK_HI: begin
        if (!sync2_q) begin
          state_d = ST_LO;
        end else if (db_cnt_q == DB_LAST) begin
          state_d = ST_HI;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      ST_HI: begin
        if (!sync2_q) begin
          state_d  = CHK_LO;
          db_cnt_d = '0;
        end
      end
      CHK_LO: begin
        if (sync2_q) begin
          state_d = ST_HI;
        end else if (db_cnt_q == DB_LAST) begin
          state_d   = ST_LO;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_LO;
    endcase
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

`ifdef BTN_LONG_PRESS_EN
  localparam int HW = cnt_w(LONG_CYC);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYC - 1);

  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          long_done_q, long_done_d;
  logic          long_q, long_d;

  always_ff @(posedge sys_clk_125 or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q  <= '0;
      long_done_q <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      hold_cnt_q  <= hold_cnt_d;
      long_done_q <= long_done_d;
      long_q      <= long_d;
    end
  end

  // A release accepted on the terminal cycle wins over the long pulse.
  always_comb begin
    hold_cnt_d  = hold_cnt_q;
    long_done_d = long_done_q;
    long_d      = 1'b0;
    if (state_d == ST_LO) begin
      hold_cnt_d  = '0;
      long_done_d = 1'b0;
    end else if (press_d) begin
      hold_cnt_d  = '0;
      long_done_d = 1'b0;
    end else if ((state_q == ST_HI || state_q == CHK_LO) && !long_done_q) begin
      if (hold_cnt_q == HOLD_LAST) begin
        long_d      = 1'b1;
        long_done_d = 1'b1;
      end else begin
        hold_cnt_d = hold_cnt_q + 1'b1;
      end
    end
  end

  assign btn_long = long_q;
`else
  logic unused_long_cfg;
  assign unused_long_cfg = (LONG_CYC != 0);
  assign btn_long        = 1'b0;
`endif

endmodule

// File: rtl/btn_conditioner.sv
// Push-button conditioner: N_BTN independent debounce channels.
// Long-press pulses are compiled in only when BTN_LONG_PRESS_EN is defined.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int N_BTN        = 4,
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
  parameter int LONG_CYC     = LONG_CYC_DEF
) (
  input  logic             sys_clk_125,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long
);

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .LONG_CYC     (LONG_CYC)
    ) u_ch (
      .sys_clk_125 (sys_clk_125),
      .rst_n       (rst_n),
      .btn         (btn[gi]),
      .btn_level   (btn_level[gi]),
      .btn_press   (btn_press[gi]),
      .btn_release (btn_release[gi]),
      .btn_long    (btn_long[gi])
    );
  end

endmodule
